register_file_wb: RTL
=====================

// Module: register_file_wb
// PURPOSE
//  Integer register file: the sink of the write-back path. Accepts write_data from the
//  write-back unit and serves two decode-stage read ports plus one debug read port.
//  Holds a per-register pending scoreboard: decode marks a destination busy, and the
//  matching write-back clears it. Decode uses the busy flags to stall on load-use hazards.
// PARAMETERS
//  XLEN       32  data width of each register
//  REG_COUNT  32  number of registers; ADDR_W = $clog2(REG_COUNT) = 5
//  BYPASS     1   1: a same-cycle write-back is forwarded to the read ports; 0: no forwarding
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  wb_en      in   1       write-back valid; writes wb_data into wb_addr
//  wb_addr    in   ADDR_W  destination register of the write-back
//  wb_data    in   XLEN    write data (write-back unit write_data output)
//  rs1_addr   in   ADDR_W  read port 1 address
//  rs2_addr   in   ADDR_W  read port 2 address
//  rs1_data   out  XLEN    read port 1 data (combinational)
//  rs2_data   out  XLEN    read port 2 data (combinational)
//  pend_set   in   1       decode issued an instruction with a deferred result to pend_addr
//  pend_addr  in   ADDR_W  register to mark pending
//  rs1_busy   out  1       rs1 has an outstanding write; decode must stall
//  rs2_busy   out  1       rs2 has an outstanding write; decode must stall
//  pend_any   out  1       OR of all pending bits (used for drain and fence)
//  dbg_addr   in   ADDR_W  debug read address
//  dbg_data   out  XLEN    debug read data (no bypass; array contents only)
// BEHAVIOUR
//  - Reset (async, rst=1): all registers = 0, all pending bits = 0. Outputs follow immediately:
//    rs*_data = 0, rs*_busy = 0, pend_any = 0, dbg_data = 0. Reset mid-write discards that write.
//  - Write: at the rising edge of clk, if wb_en && wb_addr!=0, then reg[wb_addr] <= wb_data.
//    The write latency is 1 clock. A write to x0 is ignored.
//  - x0: always reads 0. It is never pending: pend_set with pend_addr=0 is ignored.
//  - Read: rsN_data = 0 if rsN_addr==0.
//    Otherwise, if BYPASS and wb_en and wb_addr==rsN_addr, rsN_data = wb_data.
//    Otherwise rsN_data = reg[rsN_addr]. Both ports are independent and may alias.
//  - Scoreboard, evaluated per register r at the clock edge:
//      set = pend_set && pend_addr==r && r!=0
//      clr = wb_en && wb_addr==r
//      pending[r] <= set ? 1 : (clr ? 0 : pending[r])
//    If set and clr occur on the same r in the same cycle, set wins (a newer producer was issued).
//  - Busy: rsN_busy = pending[rsN_addr] && !(BYPASS && wb_en && wb_addr==rsN_addr).
//    A register whose result arrives this cycle is not busy when BYPASS=1.
//    A pend_set in the same cycle does not affect busy until the next cycle.
//  - wb_en to a register that is not pending is legal: it writes and leaves pending at 0.
//  - All addresses are full ADDR_W width, so every address value is in range.
//    REG_COUNT must be a power of 2.
// TESTING
//  1 Reset: write x5=0x11 and assert rst mid-cycle -> rs1_data(x5)=0 at once; pend_any=0.
//  2 Write/read: wb_en, x3 <- 0xA5A5A5A5; next cycle rs1_addr=3 -> 0xA5A5A5A5.
//    Write to x0 with 0xFFFFFFFF -> rs2_data(x0)=0.
//  3 Bypass: same cycle wb_en x7<-0x1234, rs1=rs2=7 -> both read 0x1234 before the edge
//    (BYPASS=1). With BYPASS=0 they read the old value.
//  4 Load-use: pend_set x9; next cycle rs1=9 -> rs1_busy=1, pend_any=1.
//    wb_en x9<-0xBBBBBBBB -> busy=0 in that cycle; the cycle after, pend_any=0 and data=0xBBBBBBBB.
//  5 Collision: pending x4, then pend_set x4 and wb_en x4 in the same cycle -> x4 stays pending,
//    and reg x4 takes the new data.
//  6 Random: 10k cycles of mixed wb/pend/read traffic checked against a reference model.
//    Check: rs*_data, rs*_busy and dbg_data every cycle; x0 is 0 throughout.

Source files
------------

// File: rtl/register_file_wb.sv
// Integer register file with write-back bypass and a per-register pending scoreboard.
// x0 is hard-wired to zero and never pending; dbg_data reads array contents only.

module rf_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            set,
  input  logic            clr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] q,
  output logic            pend
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (we) q <= wdata;
      // a newer producer issued in the same cycle outranks the retiring write
      if (set)      pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end
endmodule

module register_file_wb #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              pend_any,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);
  logic [REG_COUNT-1:0][XLEN-1:0] regs;
  logic [REG_COUNT-1:0]           pend;

  assign regs[0] = '0;
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
    rf_entry #(.XLEN(XLEN)) u_entry (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_en && wb_addr == ADDR_W'(r)),
      .set   (pend_set && pend_addr == ADDR_W'(r)),
      .clr   (wb_en && wb_addr == ADDR_W'(r)),
      .wdata (wb_data),
      .q     (regs[r]),
      .pend  (pend[r])
    );
  end

  // forwarding is suppressed under reset so outputs read zero immediately
  logic byp1, byp2;
  assign byp1 = (BYPASS != 0) && !rst && wb_en && (wb_addr == rs1_addr);
  assign byp2 = (BYPASS != 0) && !rst && wb_en && (wb_addr == rs2_addr);

  assign rs1_data = (rs1_addr == '0) ? '0 : (byp1 ? wb_data : regs[rs1_addr]);
  assign rs2_data = (rs2_addr == '0) ? '0 : (byp2 ? wb_data : regs[rs2_addr]);
  assign rs1_busy = pend[rs1_addr] && !byp1;
  assign rs2_busy = pend[rs2_addr] && !byp2;
  assign pend_any = |pend;
  assign dbg_data = regs[dbg_addr];
endmodule
